counter_demux: RTL and testbench

- Programmable wait-timer for the HD44780 LCD controller sequencer.
- Contains four free-running modulo counters, each with its own period, and a one-hot decoder (demux) that selects which counter's terminal tick appears on the single `flag` output.
- The sequencer sets `sel` to pick a delay class (enable pulse, instruction process time, 10 ms, 100 ms) and pulses `restart` to align all counters.
- The sequencer then waits for `flag`.

---
 rtl/counter_demux_pkg.sv | 26 ++
 rtl/counter_demux_counter.sv | 41 ++++
 rtl/counter_demux_demux.sv | 20 ++
 rtl/counter_demux.sv | 63 ++++++
 tb/tb_counter_demux.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/counter_demux_pkg.sv
// rtl/counter_demux_pkg.sv - shared constants and helpers for the LCD wait-timer
//
// Contents:
//   WAIT_*     default channel periods in clk cycles
//   sel_e      delay-class selector encodings
//   cnt_width  counter width needed to hold 0 .. count-1 (at least 1 bit)
package counter_demux_pkg;

  localparam int WAIT_EN    = 2;
  localparam int WAIT_INST  = 20;
  localparam int WAIT_10MS  = 2500;
  localparam int WAIT_100MS = 25000;

  typedef enum logic [1:0] {
    SEL_EN    = 2'd0,
    SEL_INST  = 2'd1,
    SEL_10MS  = 2'd2,
    SEL_100MS = 2'd3
  } sel_e;

  // A period of 1 still needs a 1-bit register.
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/counter_demux_counter.sv
// rtl/counter_demux_counter.sv - free-running modulo-COUNT counter with terminal tick
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset, loads RESET
//   restart  synchronous clear to 0, wins over wrap
//   flag     high while the count sits at COUNT-1
module counter
  import counter_demux_pkg::*;
#(
  parameter int COUNT = 2,
  parameter int RESET = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic flag
);

  localparam int W = cnt_width(COUNT);
  localparam logic [W-1:0] LAST    = W'(COUNT - 1);
  localparam logic [W-1:0] RST_VAL = W'(RESET);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With COUNT == 1 the count never leaves 0, so the tick is stuck high.
  assign flag = (cnt == LAST);

endmodule

// File: rtl/counter_demux_demux.sv
// rtl/counter_demux_demux.sv - binary to one-hot decoder with a reserved top bit
//
// Ports:
//   val  binary select value
//   sel  one-hot decode, bit[val] set; bit[2**BITS] is reserved and always 0
module demux #(
  parameter int BITS = 2
) (
  input  logic [BITS-1:0]  val,
  output logic [2**BITS:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < 2**BITS; i++) begin
      sel[i] = (val == BITS'(i));
    end
  end

endmodule

// File: rtl/counter_demux.sv
// rtl/counter_demux.sv - four-channel LCD wait-timer with selectable terminal flag
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   restart  synchronous clear of every channel counter
//   sel      delay-class select
//   onehot   decoded sel (top bit reserved, 0)
//   tick     per-channel terminal-count pulses
//   flag     tick of the selected channel, no added latency
module counter_demux
  import counter_demux_pkg::*;
#(
  parameter int BITS   = 2,
  parameter int COUNT0 = WAIT_EN,
  parameter int COUNT1 = WAIT_INST,
  parameter int COUNT2 = WAIT_10MS,
  parameter int COUNT3 = WAIT_100MS,
  parameter int RESET  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic [BITS-1:0]    sel,
  output logic [2**BITS:0]   onehot,
  output logic [2**BITS-1:0] tick,
  output logic               flag
);

  localparam int N = 2**BITS;

  function automatic int period(input int idx);
    case (idx)
      0:       return COUNT0;
      1:       return COUNT1;
      2:       return COUNT2;
      default: return COUNT3;
    endcase
  endfunction

  // Every channel runs all the time; sel only chooses which tick reaches flag.
  for (genvar g = 0; g < N; g++) begin : g_chan
    counter #(
      .COUNT(period(g)),
      .RESET(RESET)
    ) u_counter (
      .clk    (clk),
      .rst    (rst),
      .restart(restart),
      .flag   (tick[g])
    );
  end

  demux #(
    .BITS(BITS)
  ) u_demux (
    .val(sel),
    .sel(onehot)
  );

  assign flag = |(tick & onehot[N-1:0]);

endmodule

// File: tb/tb_counter_demux.sv
// tb/tb_counter_demux.sv - directed self-checking bench for counter_demux
module tb_counter_demux;

  logic       clk;
  logic       rst;
  logic       restart;
  logic [1:0] sel;
  logic [4:0] onehot;
  logic [3:0] tick;
  logic       flag;

  int errors = 0;
  int checks = 0;

  counter_demux #(
    .BITS  (2),
    .COUNT0(2),
    .COUNT1(5),
    .COUNT2(7),
    .COUNT3(11),
    .RESET (0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .sel    (sel),
    .onehot (onehot),
    .tick   (tick),
    .flag   (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected tick vector k edges after all counters were at 0.
  function automatic logic [3:0] exp_tick(input int k);
    return {(k % 11) == 10, (k % 7) == 6, (k % 5) == 4, (k % 2) == 1};
  endfunction

  initial begin
    rst = 1'b1;
    restart = 1'b0;
    sel = 2'd0;
    #12;

    // Reset state and demux sweep while counters are frozen.
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_flag", 32'(flag), 32'h0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("onehot", 32'(onehot), 32'(5'b00001 << s));
      chk("reset_flag_sel", 32'(flag), 32'h0);
    end

    // Periodicity on channel 1 after release.
    @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 2'd1;
    #1;
    chk("release_flag", 32'(flag), 32'h0);
    for (int k = 1; k <= 19; k++) begin
      step();
      chk("period_ch1", 32'(flag), 32'((k % 5) == 4));
    end

    // Restart alignment on channel 2.
    restart = 1'b1;
    step();
    restart = 1'b0;
    sel = 2'd2;
    #1;
    chk("restart_tick", 32'(tick), 32'h0);
    for (int d = 1; d <= 21; d++) begin
      step();
      chk("align_ch2", 32'(flag), 32'((d % 7) == 6));
    end

    // Select switching: channel 0, then channel 3 in the same cycle.
    restart = 1'b1;
    sel = 2'd0;
    step();
    restart = 1'b0;
    for (int d = 1; d <= 10; d++) begin
      step();
      chk("sw_ch0", 32'(flag), 32'((d % 2) == 1));
    end
    sel = 2'd3;
    #1;
    chk("sw_same_cycle", 32'(flag), 32'h1);
    for (int d = 11; d <= 23; d++) begin
      step();
      chk("sw_ch3", 32'(flag), 32'((d % 11) == 10));
    end

    // Restart priority and hold on channel 1 (cnt1 == 3 here).
    sel = 2'd1;
    #1;
    chk("hold_pre", 32'(flag), 32'h0);
    step();
    chk("hold_at4", 32'(tick[1]), 32'h1);
    restart = 1'b1;
    for (int h = 0; h < 3; h++) begin
      step();
      chk("hold_tick1", 32'(tick[1]), 32'h0);
      chk("hold_flag", 32'(flag), 32'h0);
    end
    restart = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("after_hold", 32'(flag), 32'(k == 4));
    end

    // Bring cnt3 to 8, then pulse reset between edges.
    sel = 2'd3;
    for (int k = 5; k <= 8; k++) begin
      step();
      chk("pre_rst_tick", 32'(tick), 32'(exp_tick(k)));
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_tick", 32'(tick), 32'h0);
    chk("async_flag", 32'(flag), 32'h0);
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("post_rst_tick", 32'(tick), 32'(exp_tick(k)));
      chk("post_rst_flag", 32'(flag), 32'((k % 11) == 10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
